instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Decoupling instruction queue between the fetch stage (PC register plus instruction memory) and the decode/control stage.
- Accepts {PC, Instr} pairs from fetch through a valid/ready handshake and buffers up to DEPTH entries in order.
- Presents the oldest entry to decode with the field slices decode consumes: imm26, imm16, rs, rt, rd, shamt.
- Flush input discards all buffered entries on a branch/jump redirect.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  fetch offers an entry.
- in_pc  input  32  PC of offered instruction.
- in_instr  input  32  offered instruction word.
- in_ready  output  1  queue can accept an entry (not full).
- out_valid  output  1  queue holds at least one entry.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  head PC.
- out_instr  output  32  head instruction.
- imm26  output  26  out_instr[25:0].
- imm16  output  16  out_instr[15:0].
- rs  output  5  out_instr[25:21].
- rt  output  5  out_instr[20:16].
- rd  output  5  out_instr[15:11].
- shamt  output  5  out_instr[10:6].
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage is DEPTH × 64-bit register array, read pointer, write pointer and count. All are registered.
- Reset (async, active-high) sets pointers to 0 and count to 0. Storage contents are don't-care.
- Outputs after reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0. All field outputs are therefore 0.
- in_ready = (count != DEPTH). It is derived from registered count only, with no combinational path from out_ready.
- out_valid = (count != 0).
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Push: writes {in_pc, in_instr} at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: the read pointer increments modulo DEPTH.
- Count: push only → +1; pop only → −1; push and pop together → unchanged.
- No bypass. An entry pushed in cycle N is visible at the head in cycle N+1 at the earliest, so minimum latency is 1 cycle.
- Full: in_ready=0, so in_valid is ignored even if a pop occurs in the same cycle. Fetch must hold its offer.
- Empty: out_valid=0 and out_pc/out_instr are forced to 0, a NOP. Asserting out_ready while empty has no effect.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no lost or duplicated entries.
- Flush dominates. When flush=1 at the edge, pointers and count go to 0 and any push or pop that cycle is discarded.
- The first entry accepted after a flush is the one offered in the cycle after flush.
- Reset asserted mid-operation discards all entries immediately, independent of clk.
- Field outputs are pure slices of out_instr.
- No X propagation: out_instr is muxed to 0 when empty.

Decomposition:
- Shared constants file (const.v) gains `NOP (32'h00000000) and `PC_RESET (32'h00003000). The second is shared with the fetch stage for bench stimulus.
- No typedefs are needed.
- Storage plus pointers are kept inline; a sub-module split is not warranted at this size.
- Field slicing can be factored into a small combinational sub-module, instr_fields. Decode and this block then slice identically.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0, out_instr=0 for 5 cycles.
- Push PC 0x3000 / instr 0x3C010001 with out_ready=0 → next cycle:
  - out_valid=1, out_pc=0x3000, count=1.
  - rt=1, imm16=0x0001.
- Push 4 entries (PC 0x3000..0x300C) with out_ready=0 → count=4 and in_ready=0. A 5th offer (0x3010) is refused and count stays 4.
- Then out_ready=1 for 4 cycles → heads are 0x3000, 0x3004, 0x3008, 0x300C in order, after which out_valid=0.
- Continuous push and pop with in_valid=out_ready=1 for 10 entries:
  - count stays 1 after the first cycle.
  - Pointers wrap twice.
  - Output PC sequence equals input sequence delayed 1 cycle.
- With 3 entries held, assert flush together with in_valid (PC 0x3020) and out_ready → next cycle count=0 and out_valid=0. PC 0x3020 is not stored, and no pop is recorded.
- With 2 entries held, assert reset asynchronously between clock edges → count=0 and out_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the fetch queue and its neighbours (fetch, decode).
package instr_fetch_queue_pkg;

  // Word driven onto the head outputs while the queue is empty.
  localparam logic [31:0] NOP      = 32'h0000_0000;
  // Reset PC of the fetch stage; also the base of the bench stimulus.
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  localparam int unsigned IFQ_DEPTH = 4;
  localparam int unsigned IFQ_AW    = 2;

  // One queue entry is {pc, instr}.
  localparam int unsigned ENTRY_W = 64;

endpackage : instr_fetch_queue_pkg

// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between fetch (producer), the queue and decode (consumer).
interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
);
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [25:0]   imm26;
  logic [15:0]   imm16;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [AW:0]   count;

  // Environment side: drives fetch offers, decode acceptance and flush.
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr,
           imm26, imm16, rs, rt, rd, shamt, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr,
           imm26, imm16, rs, rt, rd, shamt, count
  );
endinterface : instr_fetch_queue_if

// File: rtl/instr_fetch_queue_instr_fields.sv
// Instruction field slicer shared with decode so both cut fields identically.
module instr_fields (
  input  logic [31:0] i_instr,
  output logic [25:0] o_imm26,
  output logic [15:0] o_imm16,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt
);
  assign o_imm26 = i_instr[25:0];
  assign o_imm16 = i_instr[15:0];
  assign o_rs    = i_instr[25:21];
  assign o_rt    = i_instr[20:16];
  assign o_rd    = i_instr[15:11];
  assign o_shamt = i_instr[10:6];
endmodule : instr_fields

// File: rtl/instr_fetch_queue.sv
// In-order {pc, instr} queue decoupling fetch from decode. No bypass: an
// entry becomes visible at the head one cycle after it is accepted.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned AW    = IFQ_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_queue_if.slave   bus
);

  if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_bad_param
    $error("instr_fetch_queue: DEPTH must be a power of two >= 2 and equal 2**AW");
  end

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW:0]        r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [31:0]        w_out_pc;
  logic [31:0]        w_out_instr;

  // Readiness comes only from the registered count, so there is no
  // combinational path from out_ready back to in_ready.
  assign w_in_ready  = (r_count != FULL_CNT);
  assign w_out_valid = (r_count != '0);
  // Flush kills both transfers in the cycle it is asserted.
  assign w_push      = bus.in_valid  & w_in_ready  & ~bus.flush;
  assign w_pop       = bus.out_valid & bus.out_ready & ~bus.flush;

  // Entry storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_pc, bus.in_instr};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at 2**AW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: empty queue shows a NOP at PC 0 so no stale data leaks.
  always_comb begin
    w_head      = r_mem[r_rd_ptr];
    w_out_pc    = 32'h0;
    w_out_instr = NOP;
    if (w_out_valid) begin
      w_out_pc    = w_head[63:32];
      w_out_instr = w_head[31:0];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_pc;
  assign bus.out_instr = w_out_instr;
  assign bus.count     = r_count;

  logic [25:0] w_imm26;
  logic [15:0] w_imm16;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;

  instr_fields u_fields (
    .i_instr (w_out_instr),
    .o_imm26 (w_imm26),
    .o_imm16 (w_imm16),
    .o_rs    (w_rs),
    .o_rt    (w_rt),
    .o_rd    (w_rd),
    .o_shamt (w_shamt)
  );

  assign bus.imm26 = w_imm26;
  assign bus.imm16 = w_imm16;
  assign bus.rs    = w_rs;
  assign bus.rt    = w_rt;
  assign bus.rd    = w_rd;
  assign bus.shamt = w_shamt;

endmodule : instr_fetch_queue

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: hand-computed expectations per step.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instr_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'h0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset, then 5 idle cycles
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
      chk("idle_in_ready",  64'(bus.in_ready),  64'd1);
      chk("idle_count",     64'(bus.count),     64'd0);
      chk("idle_out_instr", 64'(bus.out_instr), 64'd0);
      chk("idle_out_pc",    64'(bus.out_pc),    64'd0);
    end

    // Single push, no pop: visible next cycle with fields
    bus.in_valid = 1'b1;
    bus.in_pc    = PC_RESET;
    bus.in_instr = 32'h3C01_0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("one_out_valid", 64'(bus.out_valid), 64'd1);
    chk("one_out_pc",    64'(bus.out_pc),    64'h3000);
    chk("one_count",     64'(bus.count),     64'd1);
    chk("one_rt",        64'(bus.rt),        64'd1);
    chk("one_imm16",     64'(bus.imm16),     64'h0001);
    chk("one_rs",        64'(bus.rs),        64'd0);
    chk("one_imm26",     64'(bus.imm26),     64'h001_0001);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("one_drain_count", 64'(bus.count),     64'd0);
    chk("one_drain_instr", 64'(bus.out_instr), 64'd0);

    // Fill to DEPTH with out_ready low
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h3000 + 32'(4 * i);
      bus.in_instr = 32'h012A_4020 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("full_count",    64'(bus.count),    64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_head_pc",  64'(bus.out_pc),   64'h3000);
    chk("full_rs",       64'(bus.rs),       64'd9);
    chk("full_rt",       64'(bus.rt),       64'd10);
    chk("full_rd",       64'(bus.rd),       64'd8);
    chk("full_shamt",    64'(bus.shamt),    64'd0);

    // 5th offer refused while full
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h3010;
    bus.in_instr = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("refuse_count", 64'(bus.count), 64'd4);

    // Drain 4; offer of 0x3010 stays up during first pop and must be ignored
    for (int i = 0; i < 4; i++) begin
      chk("drain_head_pc",    64'(bus.out_pc),    64'(32'h3000 + 32'(4 * i)));
      chk("drain_head_instr", 64'(bus.out_instr), 64'(32'h012A_4020 + 32'(i)));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_count",     64'(bus.count),     64'd0);

    // Continuous push+pop of 10 entries; head trails input by one cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        chk("stream_head_pc", 64'(bus.out_pc), 64'(32'h3100 + 32'(4 * (i - 1))));
        chk("stream_count",   64'(bus.count),  64'd1);
      end
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h3100 + 32'(4 * i);
      bus.in_instr = 32'h2000_0000 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("stream_last_pc",    64'(bus.out_pc),    64'h3124);
    chk("stream_last_instr", 64'(bus.out_instr), 64'h2000_0009);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stream_end_count", 64'(bus.count), 64'd0);

    // Hold 3 entries, then flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h3040 + 32'(4 * i);
      bus.in_instr = 32'h1000_0000 + 32'(i);
      @(negedge clk);
    end
    chk("preflush_count", 64'(bus.count), 64'd3);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h3020;
    bus.in_instr  = 32'h0BAD_0000;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_pc     = 32'h3050;
    bus.in_instr  = 32'h1111_2222;
    chk("flush_count",     64'(bus.count),     64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_out_pc",    64'(bus.out_pc),    64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("postflush_count", 64'(bus.count),     64'd1);
    chk("postflush_pc",    64'(bus.out_pc),    64'h3050);
    chk("postflush_instr", 64'(bus.out_instr), 64'h1111_2222);

    // Async reset between edges with 2 entries held
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h3060;
    bus.in_instr = 32'h3333_4444;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("prereset_count", 64'(bus.count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count",     64'(bus.count),     64'd0);
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_count", 64'(bus.count),  64'd0);
    chk("after_reset_pc",    64'(bus.out_pc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_fetch_queue
